// File: rtl/lsq_load_arbiter.sv
// Load-port arbiter: N requesters share one LSQ load port, and returns are routed back in issue order.
// Latency: zero cycles on both channels. The address and data paths are combinational, and only ID state is registered.
// Backpressure: a stalled grant is locked until it issues. Issue blocks when the ID FIFO is full. A return stalls until its requester is ready.

// Issued requester IDs: a small FIFO kept in issue order.
// Latency: the head is visible in the cycle after the push. Push and pop may happen in the same cycle.
// Backpressure: none internally. The caller must not push when full or pop when empty.
module lsq_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pushVld,
  input  logic [WIDTH-1:0]           pushDat,
  input  logic                       popVld,
  output logic [WIDTH-1:0]           headDat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  assign headDat = mem[rdPtr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // Storage is left unreset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (pushVld) begin
      mem[wrPtr] <= pushDat;
    end
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushVld) wrPtr <= wrPtr + PTR_W'(1);
      if (popVld)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(pushVld) - CNT_W'(popVld);
    end
  end
endmodule

module lsq_load_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32,
  parameter int ID_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_TYPE-1:0]   addrIn,
  input  logic [NUM_PORTS-1:0]             addrIn_valid,
  output logic [NUM_PORTS-1:0]             addrIn_ready,
  output logic [ADDR_TYPE-1:0]             addrOut,
  output logic                             addrOut_valid,
  input  logic                             addrOut_ready,
  input  logic [DATA_TYPE-1:0]             dataFromMem,
  input  logic                             dataFromMem_valid,
  output logic                             dataFromMem_ready,
  output logic [NUM_PORTS*DATA_TYPE-1:0]   dataOut,
  output logic [NUM_PORTS-1:0]             dataOut_valid,
  input  logic [NUM_PORTS-1:0]             dataOut_ready,
  output logic [$clog2(ID_DEPTH+1)-1:0]    outstanding
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0] prio;
  logic             locked;
  logic [IDX_W-1:0] lockIdx;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic [IDX_W-1:0] head;
  logic             full;
  logic             empty;
  logic             issue;
  logic             pop;

  lsq_id_fifo #(.WIDTH(IDX_W), .DEPTH(ID_DEPTH)) idFifo (
    .clk     (clk),
    .rst     (rst),
    .pushVld (issue),
    .pushDat (sel),
    .popVld  (pop),
    .headDat (head),
    .count   (outstanding),
    .full    (full),
    .empty   (empty)
  );

  // A locked grant holds its port; otherwise pick the first valid port at or after prio.
  always_comb begin
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] candIdx;
    sel     = '0;
    found   = 1'b0;
    cand    = '0;
    candIdx = '0;
    if (locked) begin
      sel   = lockIdx;
      found = addrIn_valid[lockIdx];
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = {1'b0, prio} + (IDX_W+1)'(k);
        if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
        candIdx = cand[IDX_W-1:0];
        if (!found && addrIn_valid[candIdx]) begin
          found = 1'b1;
          sel   = candIdx;
        end
      end
    end
  end

  assign addrOut_valid = rst & found & ~full;
  assign issue         = addrOut_valid & addrOut_ready;

  // Mux the selected address out, and hand ready back to that port only.
  always_comb begin
    addrOut      = '0;
    addrIn_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == IDX_W'(i)) begin
        addrOut         = addrIn[i*ADDR_TYPE +: ADDR_TYPE];
        addrIn_ready[i] = rst & found & addrOut_ready & ~full;
      end
    end
  end

  assign dataFromMem_ready = rst & ~empty & dataOut_ready[head];
  assign pop               = dataFromMem_valid & dataFromMem_ready;
  assign dataOut           = {NUM_PORTS{dataFromMem}};

  // Returned data is offered only to the requester at the FIFO head.
  always_comb begin
    dataOut_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (head == IDX_W'(i)) begin
        dataOut_valid[i] = rst & ~empty & dataFromMem_valid;
      end
    end
  end

  // Advance the priority past each winner, and lock any grant that is offered but not taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio    <= '0;
      locked  <= 1'b0;
      lockIdx <= '0;
    end else begin
      if (issue) begin
        prio <= (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + IDX_W'(1);
      end
      locked  <= addrOut_valid & ~addrOut_ready;
      lockIdx <= sel;
    end
  end
endmodule

// File: tb/tb_lsq_load_arbiter.sv
module tb_lsq_load_arbiter;
  localparam int NP  = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DEP = 4;

  localparam logic [AW-1:0] A0 = 32'hA000_0A00;
  localparam logic [AW-1:0] A1 = 32'hB111_1B11;
  localparam logic [DW-1:0] D1 = 32'hDEAD_0001;
  localparam logic [DW-1:0] D2 = 32'h1234_5678;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*AW-1:0]  addrIn;
  logic [NP-1:0]     addrIn_valid;
  logic [NP-1:0]     addrIn_ready;
  logic [AW-1:0]     addrOut;
  logic              addrOut_valid;
  logic              addrOut_ready;
  logic [DW-1:0]     dataFromMem;
  logic              dataFromMem_valid;
  logic              dataFromMem_ready;
  logic [NP*DW-1:0]  dataOut;
  logic [NP-1:0]     dataOut_valid;
  logic [NP-1:0]     dataOut_ready;
  logic [2:0]        outstanding;

  int nCmp = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  lsq_load_arbiter #(.NUM_PORTS(NP), .DATA_TYPE(DW), .ADDR_TYPE(AW), .ID_DEPTH(DEP)) dut (
    .clk               (clk),
    .rst               (rst),
    .addrIn            (addrIn),
    .addrIn_valid      (addrIn_valid),
    .addrIn_ready      (addrIn_ready),
    .addrOut           (addrOut),
    .addrOut_valid     (addrOut_valid),
    .addrOut_ready     (addrOut_ready),
    .dataFromMem       (dataFromMem),
    .dataFromMem_valid (dataFromMem_valid),
    .dataFromMem_ready (dataFromMem_ready),
    .dataOut           (dataOut),
    .dataOut_valid     (dataOut_valid),
    .dataOut_ready     (dataOut_ready),
    .outstanding       (outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic ar, input logic dv, input logic [NP-1:0] dr);
    addrIn_valid      = v;
    addrOut_ready     = ar;
    dataFromMem_valid = dv;
    dataOut_ready     = dr;
    #1;
  endtask

  initial begin
    addrIn      = {A1, A0};
    dataFromMem = D1;
    rst         = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 2'b11);

    // Outputs must be quiet while reset is held, even with every input active.
    tick();
    chk("rst_addrOut_valid", 64'(addrOut_valid), 64'(0));
    chk("rst_addrIn_ready", 64'(addrIn_ready), 64'(0));
    chk("rst_dfm_ready", 64'(dataFromMem_ready), 64'(0));
    chk("rst_dataOut_valid", 64'(dataOut_valid), 64'(0));
    tick();
    rst = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 2'b00);
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("idle_addrOut_valid", 64'(addrOut_valid), 64'(0));

    // Contention: ports 0 and 1 both valid, so grants alternate 0,1,0,1 until the FIFO is full.
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("cont1_addr", 64'(addrOut), 64'(A0));
    chk("cont1_ready", 64'(addrIn_ready), 64'(2'b01));
    chk("cont1_valid", 64'(addrOut_valid), 64'(1));
    tick();
    chk("cont2_addr", 64'(addrOut), 64'(A1));
    chk("cont2_ready", 64'(addrIn_ready), 64'(2'b10));
    tick();
    chk("cont3_addr", 64'(addrOut), 64'(A0));
    tick();
    chk("cont4_addr", 64'(addrOut), 64'(A1));
    tick();

    // Full: four IDs are outstanding, so issue is blocked.
    chk("full_outstanding", 64'(outstanding), 64'(4));
    chk("full_addrOut_valid", 64'(addrOut_valid), 64'(0));
    chk("full_addrIn_ready", 64'(addrIn_ready), 64'(0));

    // A return pops head=0; issue stays blocked in that same cycle. Data is broadcast to every slice.
    drive(2'b11, 1'b1, 1'b1, 2'b11);
    chk("ret0_dout_valid", 64'(dataOut_valid), 64'(2'b01));
    chk("ret0_dfm_ready", 64'(dataFromMem_ready), 64'(1));
    chk("ret0_slice0", 64'(dataOut[31:0]), 64'(D1));
    chk("ret0_slice1", 64'(dataOut[63:32]), 64'(D1));
    chk("ret0_full_block", 64'(addrOut_valid), 64'(0));
    tick();
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("after_pop_outstanding", 64'(outstanding), 64'(3));
    chk("after_pop_valid", 64'(addrOut_valid), 64'(1));
    chk("after_pop_addr", 64'(addrOut), 64'(A0));
    tick();
    // The FIFO now holds 1,0,1,0 in order, and its write pointer has wrapped.

    // Routing backpressure: head=1, but requester 1 is not ready.
    dataFromMem = D2;
    drive(2'b00, 1'b0, 1'b1, 2'b01);
    chk("bp_dfm_ready", 64'(dataFromMem_ready), 64'(0));
    chk("bp_dout_valid", 64'(dataOut_valid), 64'(2'b10));
    tick();
    chk("bp_no_pop", 64'(outstanding), 64'(4));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("bp_release_ready", 64'(dataFromMem_ready), 64'(1));
    chk("bp_release_slice1", 64'(dataOut[63:32]), 64'(D2));
    tick();
    chk("pop2_dout_valid", 64'(dataOut_valid), 64'(2'b01));
    tick();
    chk("pop3_outstanding", 64'(outstanding), 64'(2));

    // Simultaneous issue (port 1) and return (head 1) at count 2; the read pointer wraps.
    drive(2'b10, 1'b1, 1'b1, 2'b11);
    chk("sim_addr", 64'(addrOut), 64'(A1));
    chk("sim_addr_valid", 64'(addrOut_valid), 64'(1));
    chk("sim_dout_valid", 64'(dataOut_valid), 64'(2'b10));
    tick();
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("sim_outstanding", 64'(outstanding), 64'(2));
    chk("sim_order0", 64'(dataOut_valid), 64'(2'b01));
    tick();
    chk("sim_order1", 64'(dataOut_valid), 64'(2'b10));
    tick();
    chk("empty_outstanding", 64'(outstanding), 64'(0));
    chk("empty_dfm_ready", 64'(dataFromMem_ready), 64'(0));
    chk("empty_dout_valid", 64'(dataOut_valid), 64'(0));

    // Stall lock: prio=0, and port 1 is granted and stalled for 3 cycles while port 0 becomes valid.
    drive(2'b10, 1'b0, 1'b0, 2'b11);
    chk("lock1_addr", 64'(addrOut), 64'(A1));
    chk("lock1_ready", 64'(addrIn_ready), 64'(0));
    tick();
    drive(2'b11, 1'b0, 1'b0, 2'b11);
    chk("lock2_addr", 64'(addrOut), 64'(A1));
    tick();
    chk("lock3_addr", 64'(addrOut), 64'(A1));
    tick();
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("lock4_addr", 64'(addrOut), 64'(A1));
    chk("lock4_ready", 64'(addrIn_ready), 64'(2'b10));
    tick();
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("lock5_addr", 64'(addrOut), 64'(A0));
    chk("lock5_ready", 64'(addrIn_ready), 64'(2'b01));
    tick();
    // prio=1 now; port 0 alone still wins through the wrap.
    chk("wrap_ready", 64'(addrIn_ready), 64'(2'b01));
    tick();
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("pre_rst_outstanding", 64'(outstanding), 64'(3));

    // Reset mid-operation with 3 outstanding and prio=1.
    rst = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 2'b11);
    chk("midrst_addr_valid", 64'(addrOut_valid), 64'(0));
    chk("midrst_addrIn_ready", 64'(addrIn_ready), 64'(0));
    chk("midrst_dfm_ready", 64'(dataFromMem_ready), 64'(0));
    chk("midrst_dout_valid", 64'(dataOut_valid), 64'(0));
    tick();
    rst = 1'b1;
    #1;
    chk("postrst_outstanding", 64'(outstanding), 64'(0));
    chk("postrst_addr", 64'(addrOut), 64'(A0));
    chk("postrst_ready", 64'(addrIn_ready), 64'(2'b01));
    chk("postrst_dfm_ready", 64'(dataFromMem_ready), 64'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
